// File: rtl/irq_arbiter.sv
// Machine-level interrupt source controller: external lines, MSIP and a 32-bit machine timer,
// masked by mie/mstatus.MIE and arbitrated into a held request for the trap sequencer.
module irq_arbiter #(
    parameter int unsigned NUM_EXT  = 4,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_EXT-1:0] ext_irq,
    input  logic               sw_irq_set,
    input  logic               sw_irq_clr,
    input  logic               mtime_we,
    input  logic               mtimecmp_we,
    input  logic [31:0]        wdata,
    input  logic [31:0]        csr_mie,
    input  logic               global_interrupt_enable,
    input  logic               hold_flag,
    input  logic               int_assert,
    output logic [7:0]         int_flag,
    output logic [3:0]         ext_id,
    output logic [31:0]        mip,
    output logic [31:0]        mtime
);

    localparam logic [7:0] INT_NONE  = 8'h00;
    localparam logic [7:0] CAUSE_MEI = 8'd11;
    localparam logic [7:0] CAUSE_MSI = 8'd3;
    localparam logic [7:0] CAUSE_MTI = 8'd7;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [NUM_EXT-1:0] ext_meta_q, ext_sync_q;
    logic               msip_q, mtip_q, meip;
    logic [31:0]        mtime_q, mtimecmp_q;
    logic [15:0]        presc_q;
    logic               tick;
    logic [1:0]         state_q, state_d;
    logic [7:0]         flag_q, flag_d;
    logic [3:0]         ext_id_q, ext_id_d, lowest_ext;
    logic               mei_en, msi_en, mti_en, latched_en;
    logic               unused_mie;

    // Bits of mie other than MEIE/MTIE/MSIE have no source behind them here.
    assign unused_mie = ^{csr_mie[31:12], csr_mie[10:8], csr_mie[6:4], csr_mie[2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_meta_q <= '0;
            ext_sync_q <= '0;
        end else begin
            ext_meta_q <= ext_irq;
            ext_sync_q <= ext_meta_q;
        end
    end

    assign meip = |ext_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip_q <= 1'b0;
        end else if (sw_irq_clr) begin
            msip_q <= 1'b0;
        end else if (sw_irq_set) begin
            msip_q <= 1'b1;
        end
    end

    assign tick = (presc_q == 16'(TICK_DIV - 1));

    // A software load of mtime restarts the prescaler so the next tick is a full period away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q <= '0;
            presc_q <= '0;
        end else if (mtime_we) begin
            mtime_q <= wdata;
            presc_q <= '0;
        end else if (tick) begin
            mtime_q <= mtime_q + 32'd1;
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp_q <= 32'hFFFF_FFFF;
            mtip_q     <= 1'b0;
        end else begin
            if (mtimecmp_we) begin
                mtimecmp_q <= wdata;
            end
            mtip_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign mei_en = global_interrupt_enable & meip   & csr_mie[11];
    assign msi_en = global_interrupt_enable & msip_q & csr_mie[3];
    assign mti_en = global_interrupt_enable & mtip_q & csr_mie[7];

    always_comb begin
        lowest_ext = '0;
        for (int i = int'(NUM_EXT) - 1; i >= 0; i--) begin
            if (ext_sync_q[i]) begin
                lowest_ext = 4'(i);
            end
        end
    end

    always_comb begin
        case (flag_q)
            CAUSE_MEI: latched_en = mei_en;
            CAUSE_MSI: latched_en = msi_en;
            CAUSE_MTI: latched_en = mti_en;
            default:   latched_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        flag_d   = flag_q;
        ext_id_d = ext_id_q;
        case (state_q)
            ST_IDLE: begin
                if (!hold_flag) begin
                    if (mei_en) begin
                        flag_d   = CAUSE_MEI;
                        ext_id_d = lowest_ext;
                        state_d  = ST_REQ;
                    end else if (msi_en) begin
                        flag_d  = CAUSE_MSI;
                        state_d = ST_REQ;
                    end else if (mti_en) begin
                        flag_d  = CAUSE_MTI;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Latched cause is never replaced; it is either taken or withdrawn.
                if (hold_flag) begin
                    flag_d  = INT_NONE;
                    state_d = ST_SERVICE;
                end else if (!latched_en) begin
                    flag_d  = INT_NONE;
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                flag_d = INT_NONE;
                if (int_assert) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                flag_d  = INT_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            flag_q   <= INT_NONE;
            ext_id_q <= '0;
        end else begin
            state_q  <= state_d;
            flag_q   <= flag_d;
            ext_id_q <= ext_id_d;
        end
    end

    assign int_flag = flag_q;
    assign ext_id   = ext_id_q;
    assign mtime    = mtime_q;
    assign mip      = {20'b0, meip, 3'b0, mtip_q, 3'b0, msip_q, 3'b0};

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Machine-level interrupt source controller for the pipelined RV32I core. Collects external interrupt lines, a software interrupt and a built-in 32-bit machine timer. It maintains the pending set (mip view), masks it with mie and the global enable, and picks the highest-priority source. It drives `int_flag` into the ID stage and holds each request until the trap sequencer has taken the trap.

## Interface
- `NUM_EXT`, 4: number of external interrupt lines (1..16).
- `TICK_DIV`, 1: mtime increments once every `TICK_DIV` clk cycles (1..65535).
- `clk` in 1: core clock.
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `ext_irq` in NUM_EXT: level-sensitive external requests, asynchronous to clk.
- `sw_irq_set` in 1: set software pending (MSIP).
- `sw_irq_clr` in 1: clear software pending.
- `mtime_we` in 1: load mtime with `wdata`.
- `mtimecmp_we` in 1: load mtimecmp with `wdata`.
- `wdata` in 32: write data for mtime/mtimecmp.
- `csr_mie` in 32: mie CSR; bits 11/7/3 = MEIE/MTIE/MSIE.
- `global_interrupt_enable` in 1: mstatus.MIE.
- `hold_flag` in 1: trap sequencer busy.
- `int_assert` in 1: trap sequencer redirect pulse.
- `int_flag` out 8: requested cause code, zero-extended; `INT_NONE` (8'h00) = no request.
- `ext_id` out 4: index of the winning external line, valid while `int_flag`==11.
- `mip` out 32: pending view; bit 11 MEIP, bit 7 MTIP, bit 3 MSIP, others 0.
- `mtime` out 32: timer count.

## Operation
- Sources:
  - MEIP = OR of the 2-flop-synchronised `ext_irq`.
  - MSIP = register; `sw_irq_set` sets it, `sw_irq_clr` clears it, and clear wins if both are asserted.
  - MTIP = registered (mtime >= mtimecmp), compared unsigned.
- Timer:
  - Prescaler counts 0..TICK_DIV-1; mtime increments on the wrap. mtime wraps from 32'hFFFFFFFF to 0.
  - `mtime_we` has priority over the increment in the same cycle, and the prescaler restarts at 0.
  - mtimecmp resets to 32'hFFFFFFFF.
- Enabled set = mip & csr_mie, gated by `global_interrupt_enable`.
- Priority, fixed: MEI (11) > MSI (3) > MTI (7). Among external lines, the lowest index wins.
- State machine (IDLE/REQ/SERVICE):
  - IDLE: if the enabled set is nonzero, latch the winner into `int_flag`/`ext_id` and go to REQ.
  - REQ: `int_flag` is held constant.
    - If `hold_flag`=1, go to SERVICE and set `int_flag`=INT_NONE.
    - Otherwise, if the latched source is no longer enabled, or `global_interrupt_enable`=0, go to IDLE and set `int_flag`=INT_NONE (withdraw).
    - A higher-priority arrival does not replace the latched request.
  - SERVICE: `int_flag`=INT_NONE. Wait for an `int_assert` pulse, then go to IDLE. Pending bits are untouched. Re-arbitration happens in IDLE on the next cycle.
- Pending bits are never cleared by this block on claim. Software must clear the source: deassert the device, `sw_irq_clr`, or rewrite mtimecmp.
- `hold_flag` seen in IDLE (trap for a synchronous exception or mret): stay in IDLE and do not raise a new request that cycle.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE.
  - `int_flag`=INT_NONE, `ext_id`=0, `mip`=0, `mtime`=0.
  - Sync flops, MSIP, MTIP and prescaler = 0; mtimecmp=32'hFFFFFFFF.
  - Reset mid-REQ/SERVICE aborts the request with no residue.
- Latency, with all enables set and in IDLE:
  - `ext_irq` rise sampled at edge 1 → MEIP visible after edge 2 → `int_flag`=11 after edge 3.
  - `sw_irq_set` at edge 1 → MSIP after edge 1 → `int_flag`=3 after edge 2.
  - mtime reaching mtimecmp after edge k → MTIP after edge k+1 → `int_flag`=7 after edge k+2.
- `int_flag` drops to INT_NONE on the first edge at which `hold_flag`=1 is sampled in REQ.
- After `int_assert` is sampled in SERVICE, at least one IDLE cycle occurs before the next request.
- All outputs are registered; `mip` reflects the registered pending bits.

## Test plan
- Reset values: hold `rst_n`=0 mid-simulation with traffic present → all outputs at reset values, mtimecmp=32'hFFFFFFFF. On release, mtime counts 0,1,2…
- External request: `ext_irq`=4'b0100 with MEIE and global enable set → `int_flag`=8'd11 and `ext_id`=2 three edges later. Then `hold_flag`=1 → `int_flag`=0 next edge. Then `int_assert` pulse → IDLE, and with the device still asserted and enable still 1 → re-request.
- Priority: MTIP and MSIP pending together, then MEIP arrives during REQ → `int_flag` stays 3 until serviced. After `int_assert`, with `sw_irq_clr` applied → next request is 11, then 7.
- Timer: TICK_DIV=1, mtimecmp=10 → MTIP after mtime=10, `int_flag`=7. Writing mtimecmp=32'hFFFFFFFF clears MTIP the next edge. `mtime_we` with value 32'hFFFFFFFF wraps to 0.
- Masking and withdraw:
  - MTIE=0 → `mip[7]`=1 but `int_flag` stays 0.
  - In REQ, drop `global_interrupt_enable` before `hold_flag` → `int_flag`=0 next edge and state IDLE.
- `sw_irq_set` and `sw_irq_clr` in the same cycle → MSIP=0.
